braille_cell_sender: RTL

- Transmit end of the 4-bit cell-code load interface: turns a slide-switch cell code plus a "send" pushbutton into a clean one-cycle Valid strobe with a stable 4-bit data word.
- Feeds the cell-code capture stage in the Braille trainer datapath.
- Provides the button synchronizer, debounce filter, single-send-per-press FSM and send counter.

---
 rtl/braille_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/braille_cell_sender.sv | 107 ++++++++++
 3 files changed

// File: rtl/braille_pkg.sv
`default_nettype none
// ============================================================================
// Module      : braille_pkg
// Description : Shared types and constants for the Braille trainer cell-code
//               send path (FSM state encoding, cell width, debounce defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package braille_pkg;

    // Width of one Braille cell code on the switch bank.
    localparam int CELL_W = 4;

    // Debounce lengths: short for simulation, ~10 ms at 50 MHz on the board.
    localparam int DEBOUNCE_CYCLES_SIM   = 4;
    localparam int DEBOUNCE_CYCLES_BOARD = 500000;

    // Send FSM states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        SEND         = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

endpackage : braille_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Single-bit two-flop synchronizer for asynchronous inputs,
//               synchronous active-high reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/braille_cell_sender.sv
`default_nettype none
// ============================================================================
// Module      : braille_cell_sender
// Description : Turns the switch cell code plus a bouncy send button into a
//               one-cycle Valid strobe with a stable Data word. One send per
//               press; a held button never repeats.
// Revision    : 1.0 - initial release
// ============================================================================
module braille_cell_sender
    import braille_pkg::*;
#(
    parameter int DATA_W          = CELL_W,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int CNT_W           = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] Sw,
    input  logic              Btn,
    output logic [DATA_W-1:0] Data,
    output logic              Valid,
    output logic              Busy,
    output logic [CNT_W-1:0]  SendCount
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] c_DB_MAX = DB_W'(DEBOUNCE_CYCLES);

    state_t              r_state;
    logic [DB_W-1:0]     r_db_cnt;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic [CNT_W-1:0]    r_send_cnt;
    logic                w_btn_s;

    sync_2ff u_btn_sync (
        .clk     (Clk),
        .rst     (Rst),
        .i_async (Btn),
        .o_sync  (w_btn_s)
    );

    // Press/release debounce FSM; Data, Valid and SendCount all move on the capture edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_db_cnt   <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_send_cnt <= '0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_btn_s) begin
                        r_state  <= DEBOUNCE;
                        r_db_cnt <= DB_W'(1);
                    end else begin
                        r_db_cnt <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!w_btn_s) begin
                        // Glitch shorter than the debounce window: drop it.
                        r_state  <= IDLE;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_DB_MAX) begin
                        r_state    <= SEND;
                        r_data     <= Sw;
                        r_valid    <= 1'b1;
                        r_send_cnt <= r_send_cnt + 1'b1;
                        r_db_cnt   <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                SEND: begin
                    r_state  <= WAIT_RELEASE;
                    r_db_cnt <= '0;
                end
                WAIT_RELEASE: begin
                    if (w_btn_s) begin
                        // Still held or bouncing: restart the release window.
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_DB_MAX) begin
                        r_state  <= IDLE;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_db_cnt <= '0;
                end
            endcase
        end
    end

    assign Data      = r_data;
    assign Valid     = r_valid;
    assign Busy      = (r_state != IDLE);
    assign SendCount = r_send_cnt;

endmodule : braille_cell_sender
`default_nettype wire
